decoder_gate_scheduler: RTL

- Shares one `decoder_2x4` instance among `N_REQ` requesters.
- Each requester submits a 2-input logic operation with a request/grant handshake: operands `a`, `b` and a 3-bit gate opcode.
- A round-robin arbiter picks one requester, drives the shared decoder with `{a,b}`, and forms the gate result as the OR of the decoder minterms selected by a per-opcode truth-table mask.
- It returns the result with a one-cycle valid pulse and the requester ID. It is the sequencing layer above the decoder-built gates.

---
 rtl/decoder_gate_scheduler_if.sv | 40 ++++
 rtl/decoder_gate_scheduler.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/decoder_gate_scheduler_if.sv
// ---------------------------------------------------------------------------
// decoder_gate_scheduler_if
//   Bundles the requester-side and result-side signals of the gate scheduler.
//
//   Handshake: each requester raises req[i] with its operands a[i], b[i] and
//   opcode op[3i+2:3i] held stable. The scheduler answers with a one-cycle
//   gnt[i] pulse; operands are captured on that same edge, so the requester
//   may change them afterwards and must drop req[i] within two cycles. The
//   result comes back later as a one-cycle result_valid pulse tagged with
//   result_id; result itself holds until the next pulse.
//
//   master : requester side (drives req/a/b/op)
//   slave  : scheduler side (drives gnt/busy/result*/op_count/dbg_state)
// ---------------------------------------------------------------------------
interface decoder_gate_scheduler_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
);
    logic [N_REQ-1:0]   req;
    logic [N_REQ-1:0]   a;
    logic [N_REQ-1:0]   b;
    logic [3*N_REQ-1:0] op;
    logic [N_REQ-1:0]   gnt;
    logic               busy;
    logic               result;
    logic               result_valid;
    logic [ID_W-1:0]    result_id;
    logic [15:0]        op_count;
    logic [1:0]         dbg_state;

    modport master (
        output req, a, b, op,
        input  gnt, busy, result, result_valid, result_id, op_count, dbg_state
    );

    modport slave (
        input  req, a, b, op,
        output gnt, busy, result, result_valid, result_id, op_count, dbg_state
    );
endinterface

// File: rtl/decoder_gate_scheduler.sv
// ---------------------------------------------------------------------------
// decoder_gate_scheduler
//   Shares one 2-to-4 decoder among N_REQ requesters. A round-robin arbiter
//   grants one requester, captures its operands, decodes {a,b} into minterms
//   and ORs the minterms selected by the opcode's truth-table mask.
//   One operation every three cycles: IDLE (grant) -> DEC -> EVAL.
//
//   Ports:
//     clk  : rising-edge clock
//     rst  : asynchronous active-high reset
//     bus  : slave modport of decoder_gate_scheduler_if
//            (req/a/b/op in; gnt/busy/result/result_valid/result_id/
//             op_count/dbg_state out)
//
//   N_REQ legal range is 2..8; ID_W must be clog2(N_REQ), minimum 1.
// ---------------------------------------------------------------------------
module decoder_2x4 (
    input  logic [1:0] in_i,
    output logic [3:0] out_o
);
    always_comb begin
        out_o       = 4'b0000;
        out_o[in_i] = 1'b1;
    end
endmodule

module decoder_gate_scheduler #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    decoder_gate_scheduler_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DEC  = 2'd1,
        EVAL = 2'd2
    } state_t;

    localparam logic [ID_W:0]   N_WIDE = (ID_W+1)'(N_REQ);
    localparam logic [ID_W-1:0] ID_MAX = ID_W'(N_REQ - 1);

    state_t            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic              a_q, a_d;
    logic              b_q, b_d;
    logic [2:0]        op_q, op_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [3:0]        dec_q, dec_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic              result_q, result_d;
    logic              result_valid_q, result_valid_d;
    logic [ID_W-1:0]   result_id_q, result_id_d;
    logic [15:0]       op_count_q, op_count_d;

    logic [3:0]        dec_out;

    // Arbitration results
    logic [2*N_REQ-1:0] req_rot;
    logic               found;
    logic [ID_W-1:0]    win_off;
    logic [ID_W:0]      win_sum;
    logic [ID_W-1:0]    win_id;
    logic [ID_W-1:0]    ptr_next;
    logic [N_REQ-1:0]   win_onehot;
    logic               sel_a;
    logic               sel_b;
    logic [2:0]         sel_op;

    // The one shared decoder.
    decoder_2x4 u_dec (
        .in_i  ({a_q, b_q}),
        .out_o (dec_out)
    );

    // Truth-table mask: bit k set means minterm k = {a,b} yields 1.
    function automatic logic [3:0] op_mask(input logic [2:0] opc);
        case (opc)
            3'd0:    op_mask = 4'b1000; // AND
            3'd1:    op_mask = 4'b1110; // OR
            3'd2:    op_mask = 4'b0111; // NAND
            3'd3:    op_mask = 4'b0001; // NOR
            3'd4:    op_mask = 4'b0110; // XOR
            3'd5:    op_mask = 4'b1001; // XNOR
            3'd6:    op_mask = 4'b0011; // NOT_A
            default: op_mask = 4'b1100; // BUF_A
        endcase
    endfunction

    // Rotating the doubled request vector right by ptr puts the requester
    // at ptr in bit 0, so the first set bit is the round-robin winner's
    // offset from ptr.
    always_comb begin : arb
        req_rot    = {bus.req, bus.req} >> ptr_q;
        found      = 1'b0;
        win_off    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req_rot[i]) begin
                found   = 1'b1;
                win_off = ID_W'(i);
            end
        end

        win_sum = {1'b0, ptr_q} + {1'b0, win_off};
        if (win_sum >= N_WIDE) begin
            win_sum = win_sum - N_WIDE;
        end
        win_id   = win_sum[ID_W-1:0];
        ptr_next = (win_id == ID_MAX) ? '0 : win_id + ID_W'(1);

        win_onehot = '0;
        sel_a      = 1'b0;
        sel_b      = 1'b0;
        sel_op     = 3'd0;
        for (int j = 0; j < N_REQ; j++) begin
            if (ID_W'(j) == win_id) begin
                win_onehot[j] = 1'b1;
                sel_a         = bus.a[j];
                sel_b         = bus.b[j];
                sel_op        = bus.op[3*j +: 3];
            end
        end
    end

    always_comb begin : next_state
        state_d        = state_q;
        ptr_d          = ptr_q;
        a_d            = a_q;
        b_d            = b_q;
        op_d           = op_q;
        id_d           = id_q;
        dec_d          = dec_q;
        gnt_d          = '0;
        result_d       = result_q;
        result_valid_d = 1'b0;
        result_id_d    = result_id_q;
        op_count_d     = op_count_q;

        case (state_q)
            IDLE: begin
                if (found) begin
                    a_d     = sel_a;
                    b_d     = sel_b;
                    op_d    = sel_op;
                    id_d    = win_id;
                    gnt_d   = win_onehot;
                    ptr_d   = ptr_next;
                    state_d = DEC;
                end
            end
            DEC: begin
                dec_d   = dec_out;
                state_d = EVAL;
            end
            EVAL: begin
                result_d       = |(dec_q & op_mask(op_q));
                result_id_d    = id_q;
                result_valid_d = 1'b1;
                op_count_d     = op_count_q + 16'd1;
                state_d        = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            ptr_q          <= '0;
            a_q            <= 1'b0;
            b_q            <= 1'b0;
            op_q           <= 3'd0;
            id_q           <= '0;
            dec_q          <= 4'd0;
            gnt_q          <= '0;
            result_q       <= 1'b0;
            result_valid_q <= 1'b0;
            result_id_q    <= '0;
            op_count_q     <= 16'd0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            a_q            <= a_d;
            b_q            <= b_d;
            op_q           <= op_d;
            id_q           <= id_d;
            dec_q          <= dec_d;
            gnt_q          <= gnt_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            result_id_q    <= result_id_d;
            op_count_q     <= op_count_d;
        end
    end

    assign bus.gnt          = gnt_q;
    assign bus.busy         = (state_q != IDLE);
    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;
    assign bus.result_id    = result_id_q;
    assign bus.op_count     = op_count_q;
    assign bus.dbg_state    = state_q;
endmodule
